// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencing controller: opcode set, FSM states, helpers.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_XOR  = 4'd2,
      OP_OR   = 4'd3,
      OP_AND  = 4'd4,
      OP_SLT  = 4'd5,
      OP_SLTU = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_e;

   function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   function automatic logic is_legal(input logic [ALU_OP_W-1:0] op);
      return op <= 4'(OP_SRA);
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the two requesters, the consumer and alu_seq_ctrl.
interface alu_seq_ctrl_if
   import alu_pkg::*;
#(
   parameter int XLEN = 32
);
   logic                r0_valid;
   logic                r0_ready;
   logic [ALU_OP_W-1:0] r0_op;
   logic [XLEN-1:0]     r0_a;
   logic [XLEN-1:0]     r0_b;
   logic                r1_valid;
   logic                r1_ready;
   logic [ALU_OP_W-1:0] r1_op;
   logic [XLEN-1:0]     r1_a;
   logic [XLEN-1:0]     r1_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [XLEN-1:0]     rsp_data;
   logic                rsp_src;
   logic                rsp_err;
   logic                busy;

   modport master (
      output r0_valid, r0_op, r0_a, r0_b,
      output r1_valid, r1_op, r1_a, r1_b,
      output rsp_ready,
      input  r0_ready, r1_ready,
      input  rsp_valid, rsp_data, rsp_src, rsp_err, busy
   );

   modport slave (
      input  r0_valid, r0_op, r0_a, r0_b,
      input  r1_valid, r1_op, r1_a, r1_b,
      input  rsp_ready,
      output r0_ready, r1_ready,
      output rsp_valid, rsp_data, rsp_src, rsp_err, busy
   );
endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU for the non-shift opcodes; shifts are sequenced by the caller.
module alu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   output logic [XLEN-1:0]     y
);
   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_XOR:  y = a ^ b;
         OP_OR:   y = a | b;
         OP_AND:  y = a & b;
         OP_SLT:  y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/alu_rr_arb.sv
// Two-way round-robin arbiter: on contention the requester other than last_grant wins.
module alu_rr_arb (
   input  logic [1:0] valid,
   input  logic       last_grant,
   input  logic       en,
   output logic [1:0] grant
);
   always_comb begin
      grant = 2'b00;
      if (en) begin
         if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
         else                grant = valid;
      end
   end
endmodule

// File: rtl/alu_seq_ctrl.sv
// Shares one ALU between two requesters: round-robin accept, one op in flight,
// iterative 1-bit/clk shifts, registered valid/ready response.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter  int XLEN    = 32,
   localparam int SHAMT_W = $clog2(XLEN)
) (
   input logic         clk,
   input logic         rst_n,
   alu_seq_ctrl_if.slave bus
);
   state_e              state;
   logic                last_grant;
   logic                en;
   logic [1:0]          grant;
   logic [ALU_OP_W-1:0] sel_op;
   logic [XLEN-1:0]     sel_a;
   logic [XLEN-1:0]     sel_b;
   logic [SHAMT_W-1:0]  sel_shamt;
   logic [XLEN-1:0]     alu_y;
   logic [ALU_OP_W-1:0] op_q;
   logic [XLEN-1:0]     acc;
   logic [SHAMT_W-1:0]  cnt;
   logic                rsp_valid_q;
   logic [XLEN-1:0]     rsp_data_q;
   logic                rsp_src_q;
   logic                rsp_err_q;
   logic                busy_q;

   function automatic logic [XLEN-1:0] shift_step(input logic [ALU_OP_W-1:0] op,
                                                  input logic [XLEN-1:0] v);
      logic signed [XLEN-1:0] v_s;
      v_s = v;
      case (op)
         OP_SLL:  return v << 1;
         OP_SRL:  return v >> 1;
         default: return v_s >>> 1;
      endcase
   endfunction

   // Ready is only offered in IDLE and never while reset is asserted.
   assign en = rst_n && (state == IDLE);

   alu_rr_arb u_arb (
      .valid      ({bus.r1_valid, bus.r0_valid}),
      .last_grant (last_grant),
      .en         (en),
      .grant      (grant)
   );

   assign bus.r0_ready = grant[0];
   assign bus.r1_ready = grant[1];

   assign sel_op    = grant[1] ? bus.r1_op : bus.r0_op;
   assign sel_a     = grant[1] ? bus.r1_a  : bus.r0_a;
   assign sel_b     = grant[1] ? bus.r1_b  : bus.r0_b;
   assign sel_shamt = sel_b[SHAMT_W-1:0];

   alu #(.XLEN(XLEN)) u_alu (
      .op (sel_op),
      .a  (sel_a),
      .b  (sel_b),
      .y  (alu_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         op_q        <= '0;
         acc         <= '0;
         cnt         <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_src_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  last_grant <= grant[1];
                  op_q       <= sel_op;
                  rsp_src_q  <= grant[1];
                  rsp_err_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  if (!is_legal(sel_op)) begin
                     rsp_data_q  <= '0;
                     rsp_err_q   <= 1'b1;
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end else if (is_shift(sel_op)) begin
                     acc <= sel_a;
                     cnt <= sel_shamt;
                     if (sel_shamt == '0) begin
                        rsp_data_q  <= sel_a;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                     end else begin
                        state <= SHIFT;
                     end
                  end else begin
                     rsp_data_q  <= alu_y;
                     rsp_valid_q <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            SHIFT: begin
               acc <= shift_step(op_q, acc);
               cnt <= cnt - SHAMT_W'(1);
               // The final step lands directly in the response register.
               if (cnt == SHAMT_W'(1)) begin
                  rsp_data_q  <= shift_step(op_q, acc);
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_src   = rsp_src_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = busy_q;

endmodule
